// File: rtl/song_sequencer_if.sv
// Bus between the song sequencer, the song ROM and the note distributor.
// master = sequencer side, slave = ROM/distributor/control side.
interface song_sequencer_if #(
    parameter int SONG_ADDR_W = 5
);
    logic                   play;
    logic                   beat;
    logic [1:0]             song_sel;
    logic                   voice_free;
    logic [SONG_ADDR_W+1:0] rom_addr;
    logic [15:0]            rom_data;
    logic                   load_new_note;
    logic [5:0]             note_to_load;
    logic [5:0]             duration_to_load;
    logic                   song_done;

    modport master (
        input  play, beat, song_sel, voice_free, rom_data,
        output rom_addr, load_new_note, note_to_load, duration_to_load, song_done
    );

    modport slave (
        output play, beat, song_sel, voice_free, rom_data,
        input  rom_addr, load_new_note, note_to_load, duration_to_load, song_done
    );
endinterface

// File: rtl/song_sequencer.sv
// Walks a per-song entry list in a synchronous ROM and issues note-load pulses.
// SONG_LOOP_EN: when defined, END wraps to entry 0 with a one-cycle song_done pulse.
module song_sequencer #(
    parameter int SONG_ADDR_W = 5
) (
    input  logic clk,
    input  logic reset,
    song_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]             state, state_n;
    logic [SONG_ADDR_W-1:0] index, index_n;
    logic [1:0]             song_q, song_n;
    logic [5:0]             beat_cnt, beat_cnt_n;
    logic [5:0]             hold_note, hold_note_n;
    logic [5:0]             hold_dur, hold_dur_n;
    logic [5:0]             note_q, note_n;
    logic [5:0]             dur_q, dur_n;
    logic                   load_q, load_n;
    logic                   done_q, done_n;
    logic                   step, finish;

    always_comb begin
        state_n     = state;
        index_n     = index;
        song_n      = song_q;
        beat_cnt_n  = beat_cnt;
        hold_note_n = hold_note;
        hold_dur_n  = hold_dur;
        note_n      = note_q;
        dur_n       = dur_q;
        load_n      = 1'b0;
`ifdef SONG_LOOP_EN
        done_n      = 1'b0;
`else
        done_n      = done_q;
`endif
        step        = 1'b0;
        finish      = 1'b0;

        if (bus.song_sel != song_q) begin
            // Song change overrides everything, even while paused.
            song_n  = bus.song_sel;
            index_n = '0;
            state_n = S_FETCH;
            done_n  = 1'b0;
        end else if (bus.play) begin
            case (state)
                S_IDLE: begin
                    index_n = '0;
                    state_n = S_FETCH;
                end
                S_FETCH: state_n = S_DECODE;
                S_DECODE: begin
                    case (bus.rom_data[15:14])
                        2'b00: begin
                            hold_note_n = bus.rom_data[13:8];
                            hold_dur_n  = bus.rom_data[7:2];
                            state_n     = S_ISSUE;
                        end
                        2'b01: begin
                            if (bus.rom_data[5:0] == 6'd0) begin
                                step = 1'b1;
                            end else begin
                                beat_cnt_n = bus.rom_data[5:0];
                                state_n    = S_WAIT;
                            end
                        end
                        default: finish = 1'b1;
                    endcase
                end
                S_ISSUE: begin
                    if (bus.voice_free) begin
                        load_n = 1'b1;
                        note_n = hold_note;
                        dur_n  = hold_dur;
                        step   = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.beat) begin
                        beat_cnt_n = beat_cnt - 6'd1;
                        if (beat_cnt == 6'd1) step = 1'b1;
                    end
                end
                default: ;
            endcase

            // Stepping past the last entry counts as an implicit END.
            if (step) begin
                if (index == '1) begin
                    finish = 1'b1;
                end else begin
                    index_n = index + 1'b1;
                    state_n = S_FETCH;
                end
            end

            if (finish) begin
`ifdef SONG_LOOP_EN
                index_n = '0;
                state_n = S_FETCH;
                done_n  = 1'b1;
`else
                state_n = S_DONE;
                done_n  = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            index     <= '0;
            song_q    <= bus.song_sel;
            beat_cnt  <= 6'd0;
            hold_note <= 6'd0;
            hold_dur  <= 6'd0;
            note_q    <= 6'd0;
            dur_q     <= 6'd0;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            index     <= index_n;
            song_q    <= song_n;
            beat_cnt  <= beat_cnt_n;
            hold_note <= hold_note_n;
            hold_dur  <= hold_dur_n;
            note_q    <= note_n;
            dur_q     <= dur_n;
            load_q    <= load_n;
            done_q    <= done_n;
        end
    end

    assign bus.rom_addr         = {song_q, index};
    assign bus.load_new_note    = load_q;
    assign bus.note_to_load     = note_q;
    assign bus.duration_to_load = dur_q;
    assign bus.song_done        = done_q;
endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: per-scenario tasks with inline checks.
// Expectations track SONG_LOOP_EN the same way the design does.
module tb_song_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] rom [0:127];

    song_sequencer_if #(.SONG_ADDR_W(5)) bus ();

    song_sequencer #(.SONG_ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    function automatic logic [15:0] e_note(input logic [5:0] n, input logic [5:0] d);
        return {2'b00, n, d, 2'b00};
    endfunction

    function automatic logic [15:0] e_adv(input logic [5:0] d);
        return {2'b01, 8'd0, d};
    endfunction

    localparam logic [15:0] E_END = 16'h8000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in IDLE with reset low ("cycle 0").
    task automatic apply_reset(input logic [1:0] sel);
        bus.song_sel = sel;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.play = 1'b1;
        bus.voice_free = 1'b1;
        apply_reset(2'd2);
        checks++;
        if (bus.load_new_note !== 1'b0 || bus.note_to_load !== 6'd0 ||
            bus.duration_to_load !== 6'd0 || bus.song_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got load=%b note=%0d dur=%0d done=%b, want 0/0/0/0",
                     bus.load_new_note, bus.note_to_load, bus.duration_to_load, bus.song_done);
        end
        checks++;
        if (bus.rom_addr !== 7'd64) begin
            errors++;
            $display("FAIL reset_rom_addr: got %0d want 64", bus.rom_addr);
        end
    endtask

    task automatic test_first_note();
        bus.play = 1'b1;
        bus.voice_free = 1'b1;
        apply_reset(2'd0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (bus.load_new_note !== (c == 4)) begin
                errors++;
                $display("FAIL first_note_pulse c=%0d: got %b want %b", c, bus.load_new_note, (c == 4));
            end
            if (c == 4) begin
                checks++;
                if (bus.note_to_load !== 6'd20 || bus.duration_to_load !== 6'd8 || bus.rom_addr !== 7'd1) begin
                    errors++;
                    $display("FAIL first_note_data: got note=%0d dur=%0d addr=%0d want 20/8/1",
                             bus.note_to_load, bus.duration_to_load, bus.rom_addr);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_note;
        bus.play = 1'b1;
        bus.voice_free = 1'b1;
        apply_reset(2'd1);
        exp_note = 6'd0;
        for (int c = 1; c <= 30; c++) begin
            // A beat during DECODE (cycle 11) must not count toward the wait.
            bus.beat = ((c - 1) == 11) || ((c - 1) == 15) || ((c - 1) == 18) || ((c - 1) == 21);
            tick();
            bus.beat = 1'b0;
            case (c)
                4:  exp_note = 6'd10;
                7:  exp_note = 6'd14;
                10: exp_note = 6'd17;
                25: exp_note = 6'd22;
                default: ;
            endcase
            checks++;
            if (bus.load_new_note !== (c == 4 || c == 7 || c == 10 || c == 25)) begin
                errors++;
                $display("FAIL chord_pulse c=%0d: got %b", c, bus.load_new_note);
            end
            checks++;
            if (bus.note_to_load !== exp_note) begin
                errors++;
                $display("FAIL chord_note c=%0d: got %0d want %0d", c, bus.note_to_load, exp_note);
            end
        end
        checks++;
        if (bus.duration_to_load !== 6'd2) begin
            errors++;
            $display("FAIL chord_dur: got %0d want 2", bus.duration_to_load);
        end
    endtask

    task automatic test_stall();
        logic bad;
        bus.play = 1'b1;
        bus.voice_free = 1'b0;
        apply_reset(2'd2);
        bad = 1'b0;
        for (int c = 1; c <= 53; c++) begin
            tick();
            if (bus.load_new_note !== 1'b0 || bus.note_to_load !== 6'd0 || bus.duration_to_load !== 6'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stall_hold: output changed while voice_free=0 (got load=%b note=%0d)",
                     bus.load_new_note, bus.note_to_load);
        end
        bus.play = 1'b0;
        bus.voice_free = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.load_new_note !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stall_paused: got pulse while play=0, want none");
        end
        bus.play = 1'b1;
        tick();
        checks++;
        if (bus.load_new_note !== 1'b1 || bus.note_to_load !== 6'd33 || bus.duration_to_load !== 6'd5) begin
            errors++;
            $display("FAIL stall_release: got load=%b note=%0d dur=%0d want 1/33/5",
                     bus.load_new_note, bus.note_to_load, bus.duration_to_load);
        end
        tick();
        checks++;
        if (bus.load_new_note !== 1'b0) begin
            errors++;
            $display("FAIL stall_single_pulse: got %b want 0", bus.load_new_note);
        end
    endtask

    task automatic test_pause();
        logic bad;
        bus.play = 1'b1;
        bus.voice_free = 1'b1;
        apply_reset(2'd3);
        tick(); tick(); tick();
        bad = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.beat = 1'b1; tick(); bus.beat = 1'b0; tick();
            if (bus.load_new_note !== 1'b0 || bus.rom_addr !== 7'd96) bad = 1'b1;
        end
        bus.play = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.beat = 1'b1; tick(); bus.beat = 1'b0; tick();
            if (bus.load_new_note !== 1'b0 || bus.rom_addr !== 7'd96) bad = 1'b1;
        end
        bus.play = 1'b1;
        bus.beat = 1'b1; tick(); bus.beat = 1'b0; tick();
        if (bus.load_new_note !== 1'b0 || bus.rom_addr !== 7'd96) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL pause_wait: left WAIT early (addr=%0d load=%b), want addr 96 no pulse",
                     bus.rom_addr, bus.load_new_note);
        end
        bus.beat = 1'b1; tick(); bus.beat = 1'b0;
        checks++;
        if (bus.rom_addr !== 7'd97) begin
            errors++;
            $display("FAIL pause_fetch: got addr %0d want 97", bus.rom_addr);
        end
        tick(); tick(); tick();
        checks++;
        if (bus.load_new_note !== 1'b1 || bus.note_to_load !== 6'd50 || bus.duration_to_load !== 6'd1) begin
            errors++;
            $display("FAIL pause_note: got load=%b note=%0d dur=%0d want 1/50/1",
                     bus.load_new_note, bus.note_to_load, bus.duration_to_load);
        end
    endtask

    task automatic test_song_change();
        bus.play = 1'b1;
        bus.voice_free = 1'b0;
        apply_reset(2'd0);
        tick(); tick(); tick();
        bus.song_sel = 2'd2;
        bus.voice_free = 1'b1;
        tick();
        checks++;
        if (bus.load_new_note !== 1'b0 || bus.rom_addr !== 7'd64 || bus.note_to_load !== 6'd0) begin
            errors++;
            $display("FAIL change_drop: got load=%b addr=%0d note=%0d want 0/64/0",
                     bus.load_new_note, bus.rom_addr, bus.note_to_load);
        end
        tick(); tick();
        checks++;
        if (bus.load_new_note !== 1'b0) begin
            errors++;
            $display("FAIL change_early: got pulse %b want 0", bus.load_new_note);
        end
        tick();
        checks++;
        if (bus.load_new_note !== 1'b1 || bus.note_to_load !== 6'd33) begin
            errors++;
            $display("FAIL change_resume: got load=%b note=%0d want 1/33", bus.load_new_note, bus.note_to_load);
        end
    endtask

    task automatic test_reset_mid();
        bus.play = 1'b1;
        bus.voice_free = 1'b1;
        apply_reset(2'd0);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.load_new_note !== 1'b0 || bus.note_to_load !== 6'd0) begin
            errors++;
            $display("FAIL reset_mid: got load=%b note=%0d want 0/0", bus.load_new_note, bus.note_to_load);
        end
    endtask

    task automatic test_index_wrap();
        logic bad;
        for (int k = 0; k < 31; k++) rom[32 + k] = e_adv(6'd0);
        rom[63] = e_note(6'd60, 6'd9);
        bus.play = 1'b1;
        bus.voice_free = 1'b1;
        apply_reset(2'd1);
        bad = 1'b0;
        for (int c = 1; c <= 65; c++) begin
            tick();
            if (bus.load_new_note !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL wrap_early: pulse before last entry, want none");
        end
        tick();
        checks++;
`ifdef SONG_LOOP_EN
        if (bus.load_new_note !== 1'b1 || bus.note_to_load !== 6'd60 || bus.song_done !== 1'b1 || bus.rom_addr !== 7'd32) begin
            errors++;
            $display("FAIL wrap_last: got load=%b note=%0d done=%b addr=%0d want 1/60/1/32",
                     bus.load_new_note, bus.note_to_load, bus.song_done, bus.rom_addr);
        end
`else
        if (bus.load_new_note !== 1'b1 || bus.note_to_load !== 6'd60 || bus.song_done !== 1'b1 || bus.rom_addr !== 7'd63) begin
            errors++;
            $display("FAIL wrap_last: got load=%b note=%0d done=%b addr=%0d want 1/60/1/63",
                     bus.load_new_note, bus.note_to_load, bus.song_done, bus.rom_addr);
        end
`endif
        tick();
        checks++;
`ifdef SONG_LOOP_EN
        if (bus.song_done !== 1'b0 || bus.rom_addr !== 7'd32) begin
            errors++;
            $display("FAIL wrap_after: got done=%b addr=%0d want 0/32", bus.song_done, bus.rom_addr);
        end
`else
        if (bus.song_done !== 1'b1 || bus.rom_addr !== 7'd63) begin
            errors++;
            $display("FAIL wrap_after: got done=%b addr=%0d want 1/63", bus.song_done, bus.rom_addr);
        end
`endif
    endtask

    task automatic test_end();
        logic       exp_done;
        logic [6:0] exp_addr;
        rom[0] = e_adv(6'd0);
        rom[1] = e_note(6'd7, 6'd3);
        rom[2] = e_adv(6'd0);
        rom[3] = E_END;
        bus.play = 1'b1;
        bus.voice_free = 1'b1;
        apply_reset(2'd0);
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c >= 9) begin
`ifdef SONG_LOOP_EN
                exp_done = (c == 10);
                exp_addr = (c == 9) ? 7'd3 : (c <= 11 ? 7'd0 : bus.rom_addr);
`else
                exp_done = (c >= 10);
                exp_addr = 7'd3;
`endif
                checks++;
                if (bus.song_done !== exp_done || bus.rom_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL end_c%0d: got done=%b addr=%0d want %b/%0d",
                             c, bus.song_done, bus.rom_addr, exp_done, exp_addr);
                end
            end
        end
    endtask

    initial begin
        bus.play = 1'b0;
        bus.beat = 1'b0;
        bus.song_sel = 2'd0;
        bus.voice_free = 1'b0;
        for (int i = 0; i < 128; i++) rom[i] = E_END;
        rom[0]  = e_note(6'd20, 6'd8);
        rom[32] = e_note(6'd10, 6'd4);
        rom[33] = e_note(6'd14, 6'd4);
        rom[34] = e_note(6'd17, 6'd4);
        rom[35] = e_adv(6'd3);
        rom[36] = e_note(6'd22, 6'd2);
        rom[64] = e_note(6'd33, 6'd5);
        rom[65] = e_note(6'd40, 6'd6);
        rom[96] = e_adv(6'd4);
        rom[97] = e_note(6'd50, 6'd1);

        test_reset();
        test_first_note();
        test_back_to_back();
        test_stall();
        test_pause();
        test_song_change();
        test_reset_mid();
        test_index_wrap();
        test_end();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/song_sequencer.md
# song_sequencer

Sequencing front end that feeds the note distributor: it walks a per-song entry list in a synchronous song ROM and issues one-cycle `load_new_note` pulses with `note_to_load` and `duration_to_load`. It issues a note only when the distributor reports a free note player. It paces chords and melody by waiting a programmed number of beats between note groups. It sits between the song ROM and the note distributor, driven by the same 48 Hz `beat` and `play` controls.

## Interface
- `SONG_ADDR_W`, default 5: entry-index width per song (32 entries per song).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `play`  in  1  high = run; low = freeze all state (pause).
- `beat`  in  1  one-cycle beat strobe (48 Hz).
- `song_sel`  in  2  song select; a change restarts the sequencer at entry 0.
- `voice_free`  in  1  high when at least one note player can accept a note.
- `rom_addr`  out  SONG_ADDR_W+2  `{song_q, index}`; ROM returns data the cycle after.
- `rom_data`  in  16  entry word.
- `load_new_note`  out  1  one-cycle note-issue pulse.
- `note_to_load`  out  6  note code; held from a pulse until the next pulse.
- `duration_to_load`  out  6  duration in beats; held like `note_to_load`.
- `song_done`  out  1  high while in DONE.

## Operation
- Entry format is selected by `rom_data[15:14]`:
  - 00 = NOTE: note `[13:8]`, duration `[7:2]`.
  - 01 = ADVANCE: delta beats `[5:0]`.
  - 10 or 11 = END.
- Registers:
  - `index` (SONG_ADDR_W)
  - `song_q` (2)
  - `beat_cnt` (6)
  - state
  - output registers
- States and transitions (all transitions gated by `play`; with `play` low nothing changes and `load_new_note` stays 0):
  - IDLE: `index` = 0. Go to FETCH.
  - FETCH: `rom_addr` is valid. Go to DECODE.
  - DECODE: sample `rom_data`.
    - NOTE: latch note and duration into holding registers, go to ISSUE.
    - ADVANCE with delta 0: `index`+1, go to FETCH.
    - ADVANCE with delta nonzero: `beat_cnt` = delta, go to WAIT_BEATS.
    - END: go to DONE.
  - ISSUE: wait for `voice_free`. When it is seen, register the outputs, pulse `load_new_note` the next cycle, `index`+1, go to FETCH.
  - WAIT_BEATS: each `beat` decrements `beat_cnt`. The beat that takes it to 0 causes `index`+1 and a move to FETCH.
  - DONE: hold `song_done`=1 and `index`.
- Index wrap: a NOTE or ADVANCE at the last index (all ones) goes to DONE instead of wrapping (treated as an implicit END).
- Song change: on any cycle where `song_sel` != `song_q`:
  - `song_q` ← `song_sel`, `index` ← 0, state ← FETCH.
  - A pending ISSUE is dropped with no pulse. `song_done` clears.
  - This takes priority over all other transitions and works even with `play` low, but with `play` low the state then freezes in FETCH.
- Simultaneous events:
  - `beat` and entry into WAIT_BEATS in the same cycle: that beat is not counted.
  - `voice_free` and `play` falling in the same cycle: no issue.

## Timing
- Reset values:
  - `load_new_note`=0, `note_to_load`=0, `duration_to_load`=0, `song_done`=0.
  - `index`=0, `song_q`=`song_sel` at reset, `beat_cnt`=0.
  - State = IDLE.
- Reset mid-operation returns to IDLE on the next edge. A pulse scheduled for that edge is suppressed.
- Note latency: FETCH at cycle t, DECODE at t+1, ISSUE at t+2. With `voice_free`=1 at t+2, `load_new_note`=1 at t+3 (outputs valid the same cycle). Back-to-back NOTE entries give one pulse every 3 cycles.
- ADVANCE of N beats: the next FETCH occurs 1 cycle after the Nth counted beat.
- `load_new_note` is never high for two consecutive cycles.

## Configuration
- `SONG_LOOP_EN`:
  - Defined: END (explicit or implicit) sets `index` ← 0 and goes to FETCH. `song_done` pulses high for exactly one cycle at the wrap.
  - Undefined: END goes to DONE. DONE is held until reset or a `song_sel` change.

## Test plan
- Reset, `play`=1, `voice_free`=1, ROM[0]=NOTE(note 6'd20, dur 6'd8) → `load_new_note`=1 for one cycle at cycle 4 after IDLE, `note_to_load`=20, `duration_to_load`=8, `rom_addr`=1 after the pulse.
- ROM = NOTE(10,4), NOTE(14,4), NOTE(17,4) (chord), ADVANCE(3), NOTE(22,2) → three pulses 3 cycles apart, then exactly three `beat` strobes before the fourth pulse carrying note 22.
- `voice_free`=0 held 50 cycles during ISSUE → no pulse, outputs unchanged; `voice_free` rises → pulse on the following cycle.
- `play` dropped during WAIT_BEATS with 2 beats remaining, 5 beats applied, then `play` raised → `beat_cnt` still 2; the 2 further beats are required before FETCH.
- Change `song_sel` 0→2 while in ISSUE → no pulse, `rom_addr`={2'b10, 0}, sequencing resumes from entry 0 of song 2.
- END at index 3: without `SONG_LOOP_EN`, `song_done`=1 held and no further `rom_addr` change; with `SONG_LOOP_EN`, a one-cycle `song_done` pulse and `rom_addr` index returns to 0.
